// File: rtl/deu_pkg.sv
// Shared types for the decode-issue unit: scheduler state encoding and GPR index width.
package deu_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SER_DRAIN = 2'd1,
    SER_WAIT  = 2'd2
  } deu_issue_st_e;

  localparam int LA64_GPR_IDX_W = 5;

endpackage

// File: rtl/deu_pair_chk.sv
// Pairing check for the second issue slot.
// Slot i1 may join i0 only when it is not serializing, both are not branches, and it does not read i0's result.
module deu_pair_chk
  import deu_pkg::*;
(
  input  logic [LA64_GPR_IDX_W-1:0] deu_i0_rd,
  input  logic                      deu_i0_rd_we,
  input  logic                      deu_i0_is_br,
  input  logic [LA64_GPR_IDX_W-1:0] deu_i1_rj,
  input  logic [LA64_GPR_IDX_W-1:0] deu_i1_rk,
  input  logic [LA64_GPR_IDX_W-1:0] deu_i1_rd,
  input  logic                      deu_i1_use_rj,
  input  logic                      deu_i1_use_rk,
  input  logic                      deu_i1_use_rd,
  input  logic                      deu_i1_is_br,
  input  logic                      deu_i1_is_ser,
  output logic                      i1_pair_ok
);

  logic i0_writes;
  logic raw_hit;

  // r0 is hardwired to zero, so a write to it never creates a dependency.
  assign i0_writes = deu_i0_rd_we && (deu_i0_rd != '0);

  assign raw_hit = i0_writes &&
                   ((deu_i1_use_rj && (deu_i1_rj == deu_i0_rd)) ||
                    (deu_i1_use_rk && (deu_i1_rk == deu_i0_rd)) ||
                    (deu_i1_use_rd && (deu_i1_rd == deu_i0_rd)));

  assign i1_pair_ok = !deu_i1_is_ser && !(deu_i0_is_br && deu_i1_is_br) && !raw_hit;

endmodule

// File: rtl/deu_issue_ctl.sv
// Decode-issue scheduler: picks 0/1/2 buffer-head entries per cycle, gated by dispatch credits,
// pairing rules, serializing-instruction sequencing and flush. Decode outputs are same-cycle.
module deu_issue_ctl
  import deu_pkg::*;
#(
  parameter int CREDITS = 8,
  parameter bit DUAL_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      deu_ib0_val,
  input  logic                      deu_ib1_val,
  input  logic [LA64_GPR_IDX_W-1:0] deu_i0_rd,
  input  logic                      deu_i0_rd_we,
  input  logic                      deu_i0_is_br,
  input  logic                      deu_i0_is_ser,
  input  logic [LA64_GPR_IDX_W-1:0] deu_i1_rj,
  input  logic [LA64_GPR_IDX_W-1:0] deu_i1_rk,
  input  logic [LA64_GPR_IDX_W-1:0] deu_i1_rd,
  input  logic                      deu_i1_use_rj,
  input  logic                      deu_i1_use_rk,
  input  logic                      deu_i1_use_rd,
  input  logic                      deu_i1_is_br,
  input  logic                      deu_i1_is_ser,
  input  logic [1:0]                dq_credit_ret,
  input  logic                      rob_empty,
  input  logic                      ser_done,
  input  logic                      flush,
  output logic                      deu_i0_decode,
  output logic                      deu_i1_decode,
  output logic                      deu_ser_busy
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  deu_issue_st_e state;
  logic [CW-1:0] credit;
  logic [CW:0]   credit_sum;
  logic [1:0]    issued;
  logic          has1;
  logic          has2;
  logic          i1_pair_ok;

  deu_pair_chk u_pair_chk (
    .deu_i0_rd     (deu_i0_rd),
    .deu_i0_rd_we  (deu_i0_rd_we),
    .deu_i0_is_br  (deu_i0_is_br),
    .deu_i1_rj     (deu_i1_rj),
    .deu_i1_rk     (deu_i1_rk),
    .deu_i1_rd     (deu_i1_rd),
    .deu_i1_use_rj (deu_i1_use_rj),
    .deu_i1_use_rk (deu_i1_use_rk),
    .deu_i1_use_rd (deu_i1_use_rd),
    .deu_i1_is_br  (deu_i1_is_br),
    .deu_i1_is_ser (deu_i1_is_ser),
    .i1_pair_ok    (i1_pair_ok)
  );

  assign has1 = (credit != '0);
  assign has2 = (credit > CW'(1));

  always_comb begin
    deu_i0_decode = 1'b0;
    case (state)
      RUN:       deu_i0_decode = deu_ib0_val && has1 && !deu_i0_is_ser && !flush;
      // The serializing instruction leaves alone once everything older has drained.
      SER_DRAIN: deu_i0_decode = deu_ib0_val && rob_empty && has1 && !flush;
      default:   deu_i0_decode = 1'b0;
    endcase
    deu_i1_decode = DUAL_EN && (state == RUN) && deu_i0_decode && deu_ib1_val &&
                    has2 && i1_pair_ok;
  end

  assign issued     = {1'b0, deu_i0_decode} + {1'b0, deu_i1_decode};
  assign credit_sum = {1'b0, credit} - (CW+1)'(issued) + (CW+1)'(dq_credit_ret);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      credit       <= CRED_MAX;
      deu_ser_busy <= 1'b0;
    end else if (flush) begin
      state        <= RUN;
      credit       <= CRED_MAX;
      deu_ser_busy <= 1'b0;
    end else begin
      credit <= credit_sum[CW-1:0];
      case (state)
        RUN: begin
          if (deu_ib0_val && deu_i0_is_ser) begin
            state        <= SER_DRAIN;
            deu_ser_busy <= 1'b1;
          end
        end
        SER_DRAIN: begin
          if (deu_i0_decode) state <= SER_WAIT;
        end
        SER_WAIT: begin
          if (ser_done) begin
            state        <= RUN;
            deu_ser_busy <= 1'b0;
          end
        end
        default: begin
          state        <= RUN;
          deu_ser_busy <= 1'b0;
        end
      endcase
    end
  end

  // Returning more credits than the dispatch queue holds means the producer lost count.
  always @(posedge clk) begin
    if (rst_n && !flush) begin
      credit_ovf_chk: assert (credit_sum <= (CW+1)'(CREDITS));
    end
  end

endmodule

// File: tb/tb_deu_issue_ctl.sv
// Bench for deu_issue_ctl: dual- and single-issue instances checked against a behavioural model.
module tb_deu_issue_ctl;

  localparam int CREDITS = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       deu_ib0_val, deu_ib1_val;
  logic [4:0] deu_i0_rd;
  logic       deu_i0_rd_we, deu_i0_is_br, deu_i0_is_ser;
  logic [4:0] deu_i1_rj, deu_i1_rk, deu_i1_rd;
  logic       deu_i1_use_rj, deu_i1_use_rk, deu_i1_use_rd;
  logic       deu_i1_is_br, deu_i1_is_ser;
  logic [1:0] dq_credit_ret;
  logic       rob_empty, ser_done, flush;
  logic       a_i0, a_i1, a_busy;
  logic       b_i0, b_i1, b_busy;

  always #5 clk = ~clk;

  deu_issue_ctl #(.CREDITS(CREDITS), .DUAL_EN(1'b1)) dut_dual (
    .clk(clk), .rst_n(rst_n),
    .deu_ib0_val(deu_ib0_val), .deu_ib1_val(deu_ib1_val),
    .deu_i0_rd(deu_i0_rd), .deu_i0_rd_we(deu_i0_rd_we),
    .deu_i0_is_br(deu_i0_is_br), .deu_i0_is_ser(deu_i0_is_ser),
    .deu_i1_rj(deu_i1_rj), .deu_i1_rk(deu_i1_rk), .deu_i1_rd(deu_i1_rd),
    .deu_i1_use_rj(deu_i1_use_rj), .deu_i1_use_rk(deu_i1_use_rk), .deu_i1_use_rd(deu_i1_use_rd),
    .deu_i1_is_br(deu_i1_is_br), .deu_i1_is_ser(deu_i1_is_ser),
    .dq_credit_ret(dq_credit_ret), .rob_empty(rob_empty), .ser_done(ser_done), .flush(flush),
    .deu_i0_decode(a_i0), .deu_i1_decode(a_i1), .deu_ser_busy(a_busy)
  );

  deu_issue_ctl #(.CREDITS(CREDITS), .DUAL_EN(1'b0)) dut_single (
    .clk(clk), .rst_n(rst_n),
    .deu_ib0_val(deu_ib0_val), .deu_ib1_val(deu_ib1_val),
    .deu_i0_rd(deu_i0_rd), .deu_i0_rd_we(deu_i0_rd_we),
    .deu_i0_is_br(deu_i0_is_br), .deu_i0_is_ser(deu_i0_is_ser),
    .deu_i1_rj(deu_i1_rj), .deu_i1_rk(deu_i1_rk), .deu_i1_rd(deu_i1_rd),
    .deu_i1_use_rj(deu_i1_use_rj), .deu_i1_use_rk(deu_i1_use_rk), .deu_i1_use_rd(deu_i1_use_rd),
    .deu_i1_is_br(deu_i1_is_br), .deu_i1_is_ser(deu_i1_is_ser),
    .dq_credit_ret(dq_credit_ret), .rob_empty(rob_empty), .ser_done(ser_done), .flush(flush),
    .deu_i0_decode(b_i0), .deu_i1_decode(b_i1), .deu_ser_busy(b_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model, index 0 = dual-issue instance, 1 = single-issue instance.
  int m_cr[2];
  bit m_drain[2];
  bit m_wait[2];
  bit e_i0[2];
  bit e_i1[2];

  function automatic bit raw_hit();
    if (!deu_i0_rd_we || deu_i0_rd == 5'd0) return 1'b0;
    return (deu_i1_use_rj && deu_i1_rj == deu_i0_rd) ||
           (deu_i1_use_rk && deu_i1_rk == deu_i0_rd) ||
           (deu_i1_use_rd && deu_i1_rd == deu_i0_rd);
  endfunction

  function automatic void model_eval();
    for (int k = 0; k < 2; k++) begin
      e_i0[k] = 1'b0;
      e_i1[k] = 1'b0;
      if (!flush) begin
        if (m_wait[k])       e_i0[k] = 1'b0;
        else if (m_drain[k]) e_i0[k] = deu_ib0_val && rob_empty && m_cr[k] >= 1;
        else                 e_i0[k] = deu_ib0_val && m_cr[k] >= 1 && !deu_i0_is_ser;
        e_i1[k] = (k == 0) && !m_drain[k] && !m_wait[k] && e_i0[k] && deu_ib1_val &&
                  m_cr[k] >= 2 && !deu_i1_is_ser && !(deu_i0_is_br && deu_i1_is_br) && !raw_hit();
      end
    end
  endfunction

  function automatic logic [1:0] legal_ret(input int want);
    int r = want;
    for (int k = 0; k < 2; k++) begin
      int h = CREDITS - m_cr[k] + int'(e_i0[k]) + int'(e_i1[k]);
      if (h < r) r = h;
    end
    return 2'(r);
  endfunction

  function automatic logic [5:0] exp_vec();
    return {e_i0[0], e_i1[0], m_drain[0] | m_wait[0], e_i0[1], e_i1[1], m_drain[1] | m_wait[1]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cr[k] = CREDITS; m_drain[k] = 1'b0; m_wait[k] = 1'b0;
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (flush) begin
        m_cr[k] = CREDITS; m_drain[k] = 1'b0; m_wait[k] = 1'b0;
      end else begin
        m_cr[k] = m_cr[k] - int'(e_i0[k]) - int'(e_i1[k]) + int'(dq_credit_ret);
        if (m_wait[k]) begin
          if (ser_done) m_wait[k] = 1'b0;
        end else if (m_drain[k]) begin
          if (e_i0[k]) begin m_drain[k] = 1'b0; m_wait[k] = 1'b1; end
        end else if (deu_ib0_val && deu_i0_is_ser) begin
          m_drain[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    deu_ib0_val = 0; deu_ib1_val = 0;
    deu_i0_rd = 5'd1; deu_i0_rd_we = 1; deu_i0_is_br = 0; deu_i0_is_ser = 0;
    deu_i1_rj = 5'd2; deu_i1_rk = 5'd3; deu_i1_rd = 5'd4;
    deu_i1_use_rj = 1; deu_i1_use_rk = 1; deu_i1_use_rd = 0;
    deu_i1_is_br = 0; deu_i1_is_ser = 0;
    dq_credit_ret = 0; rob_empty = 0; ser_done = 0; flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    model_eval();
    #1;
    n_chk++;
    if ({a_i0, a_i1, a_busy, b_i0, b_i1, b_busy} !== 6'b0)
      $display("FAIL reset: got %b want %b", {a_i0, a_i1, a_busy, b_i0, b_i1, b_busy}, 6'b0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_dual_issue();
    idle_inputs();
    deu_ib0_val = 1; deu_ib1_val = 1;
    for (int c = 0; c < 2; c++) begin
      model_eval();
      #1;
      n_chk++;
      if ({a_i0, a_i1, a_busy, b_i0, b_i1, b_busy} !== exp_vec() || m_cr[0] != CREDITS - 2 * c)
        $display("FAIL dual_issue c%0d: got %b want %b credit_model %0d",
                 c, {a_i0, a_i1, a_busy, b_i0, b_i1, b_busy}, exp_vec(), m_cr[0]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_raw();
    idle_inputs();
    deu_ib0_val = 1; deu_ib1_val = 1;
    deu_i0_rd = 5'd5; deu_i0_rd_we = 1; deu_i1_rj = 5'd5; deu_i1_use_rj = 1;
    for (int c = 0; c < 2; c++) begin
      deu_i0_rd = (c == 0) ? 5'd5 : 5'd0;
      model_eval();
      dq_credit_ret = legal_ret(2);
      #1;
      n_chk++;
      if ({a_i0, a_i1, a_busy, b_i0, b_i1, b_busy} !== exp_vec() || a_i1 !== (c == 1))
        $display("FAIL raw c%0d: got %b want %b", c, {a_i0, a_i1, a_busy, b_i0, b_i1, b_busy}, exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_credit();
    idle_inputs();
    deu_ib0_val = 1; deu_ib1_val = 1;
    for (int c = 0; c < 7; c++) begin
      // Let credits run dry, then return 2 at zero: issue must wait a cycle.
      model_eval();
      dq_credit_ret = (m_cr[0] == 0) ? legal_ret(2) : 2'd0;
      #1;
      n_chk++;
      if ({a_i0, a_i1, a_busy, b_i0, b_i1, b_busy} !== exp_vec())
        $display("FAIL credit c%0d: got %b want %b cr=%0d", c,
                 {a_i0, a_i1, a_busy, b_i0, b_i1, b_busy}, exp_vec(), m_cr[0]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_serialize();
    idle_inputs();
    deu_ib0_val = 1; deu_ib1_val = 1; deu_i0_is_ser = 1;
    for (int c = 0; c < 9; c++) begin
      rob_empty = (c >= 4);
      ser_done  = (c == 7);
      model_eval();
      dq_credit_ret = legal_ret(2);
      #1;
      n_chk++;
      if ({a_i0, a_i1, a_busy, b_i0, b_i1, b_busy} !== exp_vec())
        $display("FAIL serialize c%0d: got %b want %b", c, {a_i0, a_i1, a_busy, b_i0, b_i1, b_busy}, exp_vec());
      else n_pass++;
      tick();
      if (c == 4) deu_i0_is_ser = 0;
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    deu_ib0_val = 1; deu_i0_is_ser = 1; rob_empty = 1;
    for (int c = 0; c < 6; c++) begin
      flush = (c == 2);
      dq_credit_ret = (c == 2) ? 2'd1 : 2'd0;
      if (c >= 3) begin deu_i0_is_ser = 0; deu_ib1_val = 1; end
      model_eval();
      if (c != 2) dq_credit_ret = legal_ret(int'(dq_credit_ret));
      #1;
      n_chk++;
      if ({a_i0, a_i1, a_busy, b_i0, b_i1, b_busy} !== exp_vec())
        $display("FAIL flush c%0d: got %b want %b", c, {a_i0, a_i1, a_busy, b_i0, b_i1, b_busy}, exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_branch_pair();
    idle_inputs();
    deu_ib0_val = 1; deu_ib1_val = 1; deu_i0_is_br = 1; deu_i1_is_br = 1;
    for (int c = 0; c < 2; c++) begin
      model_eval();
      dq_credit_ret = legal_ret(2);
      #1;
      n_chk++;
      if ({a_i0, a_i1, a_busy, b_i0, b_i1, b_busy} !== exp_vec() || a_i1 !== 1'b0)
        $display("FAIL branch_pair c%0d: got %b want %b", c, {a_i0, a_i1, a_busy, b_i0, b_i1, b_busy}, exp_vec());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    deu_ib0_val = 1; deu_i0_is_ser = 1; rob_empty = 0;
    model_eval();
    tick();
    model_eval();
    #1;
    n_chk++;
    if ({a_busy, b_busy} !== 2'b11)
      $display("FAIL reset_mid_pre: got %b want %b", {a_busy, b_busy}, 2'b11);
    else n_pass++;
    rst_n = 1'b0;
    model_reset();
    model_eval();
    #1;
    n_chk++;
    if ({a_i0, a_i1, a_busy, b_i0, b_i1, b_busy} !== exp_vec())
      $display("FAIL reset_mid_async: got %b want %b", {a_i0, a_i1, a_busy, b_i0, b_i1, b_busy}, exp_vec());
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    deu_ib0_val = 1; deu_ib1_val = 1;
    // Full credit after reset: four dual issues, then the fifth cycle stalls.
    for (int c = 0; c < 5; c++) begin
      model_eval();
      #1;
      n_chk++;
      if ({a_i0, a_i1} !== {e_i0[0], e_i1[0]} || {a_i0, a_i1} !== ((c < 4) ? 2'b11 : 2'b00))
        $display("FAIL reset_mid_credit c%0d: got %b want %b", c, {a_i0, a_i1}, {e_i0[0], e_i1[0]});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      deu_ib0_val   = ($urandom_range(0, 3) != 0);
      deu_ib1_val   = ($urandom_range(0, 3) != 0);
      deu_i0_rd     = 5'($urandom_range(0, 3));
      deu_i0_rd_we  = 1'($urandom_range(0, 1));
      deu_i0_is_br  = ($urandom_range(0, 3) == 0);
      deu_i0_is_ser = ($urandom_range(0, 7) == 0);
      deu_i1_rj     = 5'($urandom_range(0, 3));
      deu_i1_rk     = 5'($urandom_range(0, 3));
      deu_i1_rd     = 5'($urandom_range(0, 3));
      deu_i1_use_rj = 1'($urandom_range(0, 1));
      deu_i1_use_rk = 1'($urandom_range(0, 1));
      deu_i1_use_rd = 1'($urandom_range(0, 1));
      deu_i1_is_br  = ($urandom_range(0, 3) == 0);
      deu_i1_is_ser = ($urandom_range(0, 7) == 0);
      rob_empty     = 1'($urandom_range(0, 1));
      ser_done      = ($urandom_range(0, 2) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      model_eval();
      dq_credit_ret = legal_ret(int'($urandom_range(0, 2)));
      #1;
      n_chk++;
      if ({a_i0, a_i1, a_busy, b_i0, b_i1, b_busy} !== exp_vec())
        $display("FAIL random c%0d: got %b want %b cr=%0d/%0d", c,
                 {a_i0, a_i1, a_busy, b_i0, b_i1, b_busy}, exp_vec(), m_cr[0], m_cr[1]);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_raw();
    test_credit();
    test_serialize();
    test_flush();
    test_branch_pair();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
